// File: rtl/timer_sequencer_pkg.sv
// Purpose: shared types and constants for the timer sequencer (FSM states, slave register map, control words).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE, S_STOP, S_PERL, S_PERH, S_CLR, S_GO, RUN, ACK,
    SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP, HALT
  } state_t;

  // Timer slave register map
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERL    = 3'd2;
  localparam logic [2:0] ADDR_PERH    = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Control register words
  localparam logic [15:0] CTRL_STOP = 16'h0008;
  localparam logic [15:0] CTRL_RUN  = 16'h0007;

  // One slave bus beat
  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  function automatic bus_t bus_idle();
    bus_t b;
    b.cs = 1'b0; b.write_n = 1'b1; b.addr = '0; b.data = '0;
    return b;
  endfunction

  function automatic bus_t bus_wr(input logic [2:0] a, input logic [15:0] d);
    bus_t b;
    b.cs = 1'b1; b.write_n = 1'b0; b.addr = a; b.data = d;
    return b;
  endfunction

  function automatic bus_t bus_rd(input logic [2:0] a);
    bus_t b;
    b.cs = 1'b1; b.write_n = 1'b1; b.addr = a; b.data = '0;
    return b;
  endfunction

endpackage

// File: rtl/timer_sequencer_tick_divider.sv
// Purpose: one event channel; counts acknowledged timer ticks down and pulses every div ticks.
// Latency: pulse is combinational in the advance cycle; counter updates on the following edge.
// Backpressure: none; div of 0 parks the counter at 0 and never pulses.
// Ports: load (restart from div), adv (one tick acknowledged), div (divisor), pulse (event out).
module tick_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             adv,
  input  logic [DIV_W-1:0] div,
  output logic             pulse
);

  logic [DIV_W-1:0] cnt;

  assign pulse = adv && (cnt == DIV_W'(1));

  // Reload samples the live divisor, so a divisor change lands at the next reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (adv && (cnt != '0)) begin
      cnt <= (cnt == DIV_W'(1)) ? div : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Purpose: drives a memory-mapped timer slave (start/stop/snapshot/irq ack) and divides its ticks into event channels.
// Latency: bus beats are registered and appear in the cycle of their state; snap_valid follows SNAP_CAP by one cycle.
// Backpressure: requests arriving while busy are dropped; irq is held by level, a stop lost to an irq is kept pending.
// Ports: cfg_* control pulses, snap_req, ch_div; tmr_* slave bus + irq; busy/running/snap_*/ev_pulse/tick_count status.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [31:0]             cfg_period,
  input  logic                    snap_req,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic [15:0]             tmr_readdata,
  input  logic                    tmr_irq,
  output logic                    busy,
  output logic                    running,
  output logic [31:0]             snap_value,
  output logic                    snap_valid,
  output logic [NUM_CH-1:0]       ev_pulse,
  output logic [31:0]             tick_count
);

  state_t      state, state_nxt;
  bus_t        bus_nxt;
  logic [31:0] period_q;
  logic        stop_pend;
  logic        start_acc;
  logic        ack;

  // S_STOP is only reachable from IDLE/RUN, so entering it is exactly start acceptance.
  assign start_acc = (state_nxt == S_STOP);
  assign ack       = (state == ACK);
  assign busy      = !((state == IDLE) || (state == RUN));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (cfg_start) state_nxt = S_STOP;
      S_STOP:   state_nxt = S_PERL;
      S_PERL:   state_nxt = S_PERH;
      S_PERH:   state_nxt = S_CLR;
      S_CLR:    state_nxt = S_GO;
      S_GO:     state_nxt = RUN;
      RUN: begin
        if (tmr_irq)                    state_nxt = ACK;
        else if (cfg_stop || stop_pend) state_nxt = HALT;
        else if (cfg_start)             state_nxt = S_STOP;
        else if (snap_req)              state_nxt = SNAP_W;
      end
      ACK:      state_nxt = RUN;
      SNAP_W:   state_nxt = SNAP_RL;
      SNAP_RL:  state_nxt = SNAP_RH;
      SNAP_RH:  state_nxt = SNAP_CAP;
      SNAP_CAP: state_nxt = RUN;
      HALT:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Bus beat for the state being entered; registered below so it lines up with that state.
  always_comb begin
    bus_nxt = bus_idle();
    unique case (state_nxt)
      S_STOP:  bus_nxt = bus_wr(ADDR_CONTROL, CTRL_STOP);
      S_PERL:  bus_nxt = bus_wr(ADDR_PERL, period_q[15:0]);
      S_PERH:  bus_nxt = bus_wr(ADDR_PERH, period_q[31:16]);
      S_CLR:   bus_nxt = bus_wr(ADDR_STATUS, 16'h0000);
      S_GO:    bus_nxt = bus_wr(ADDR_CONTROL, CTRL_RUN);
      ACK:     bus_nxt = bus_wr(ADDR_STATUS, 16'h0000);
      SNAP_W:  bus_nxt = bus_wr(ADDR_SNAPL, 16'h0000);
      SNAP_RL: bus_nxt = bus_rd(ADDR_SNAPL);
      SNAP_RH: bus_nxt = bus_rd(ADDR_SNAPH);
      HALT:    bus_nxt = bus_wr(ADDR_CONTROL, CTRL_STOP);
      default: bus_nxt = bus_idle();
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      tmr_chipselect <= bus_nxt.cs;
      tmr_write_n    <= bus_nxt.write_n;
      tmr_address    <= bus_nxt.addr;
      tmr_writedata  <= bus_nxt.data;
    end
  end

  // Datapath and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= '0;
      stop_pend  <= 1'b0;
      running    <= 1'b0;
      tick_count <= '0;
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (start_acc) period_q <= cfg_period;

      // A stop that loses to an irq (or lands mid-sequence) is remembered and honoured from RUN.
      if (state_nxt == HALT)      stop_pend <= 1'b0;
      else if (cfg_stop && running) stop_pend <= 1'b1;

      if (state == S_GO)      running <= 1'b1;
      else if (state == HALT) running <= 1'b0;

      if (start_acc) tick_count <= '0;
      else if (ack)  tick_count <= tick_count + 32'd1;

      // readdata trails the address by one cycle: SNAPL data arrives in SNAP_RH, SNAPH in SNAP_CAP.
      if (state == SNAP_RH)  snap_value[15:0]  <= tmr_readdata;
      if (state == SNAP_CAP) snap_value[31:16] <= tmr_readdata;
      snap_valid <= (state == SNAP_CAP);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_divider #(.DIV_W(DIV_W)) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (start_acc),
      .adv     (ack),
      .div     (ch_div[i*DIV_W +: DIV_W]),
      .pulse   (ev_pulse[i])
    );
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Purpose: self-checking bench for timer_sequencer with a behavioural timer slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        snap_req = 1'b0;
  logic [31:0] ch_div = '0;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata = '0;
  logic        tmr_irq = 1'b0;
  logic        busy;
  logic        running;
  logic [31:0] snap_value;
  logic        snap_valid;
  logic [3:0]  ev_pulse;
  logic [31:0] tick_count;

  logic        irq_raise = 1'b0;

  timer_sequencer #(.NUM_CH(4), .DIV_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_period     (cfg_period),
    .snap_req       (snap_req),
    .ch_div         (ch_div),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .busy           (busy),
    .running        (running),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid),
    .ev_pulse       (ev_pulse),
    .tick_count     (tick_count)
  );

  always #5 clk = ~clk;

  // Timer slave: registered read data, irq held until STATUS is written.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? 16'h1234 :
                      (tmr_address == 3'd5) ? 16'h0005 : 16'h0000;
    if (irq_raise) tmr_irq <= 1'b1;
    else if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) tmr_irq <= 1'b0;
  end

  // Bus/event monitor, sampled mid-cycle.
  logic [2:0]  log_a[$];
  logic [15:0] log_d[$];
  logic        log_wn[$];
  int          log_c[$];
  int          cyc = 0;
  int          pcnt[4] = '{0, 0, 0, 0};
  int          snap_cnt = 0;
  logic [31:0] snap_last = '0;
  int          run_rise_cyc = -1;
  logic        run_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (tmr_chipselect) begin
      log_a.push_back(tmr_address);
      log_d.push_back(tmr_writedata);
      log_wn.push_back(tmr_write_n);
      log_c.push_back(cyc);
    end
    for (int i = 0; i < 4; i++) if (ev_pulse[i]) pcnt[i]++;
    if (snap_valid) begin
      snap_cnt++;
      snap_last = snap_value;
    end
    if (running && !run_prev) run_rise_cyc = cyc;
    run_prev = running;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } bw_t;

  typedef struct {
    logic [31:0]     div;
    int              n_irq;
    logic [3:0][7:0] exp_p;
  } vec_t;

  bw_t  seq_exp[5];
  vec_t vecs[3];

  task automatic wait_not_busy(input string nm);
    int n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk({nm, " busy timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic start_timer(input logic [31:0] per);
    cfg_period = per;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("start busy", {31'd0, busy}, 32'd1);
    wait_not_busy("start");
    @(negedge clk);
  endtask

  task automatic do_irq();
    int n = 0;
    irq_raise = 1'b1;
    @(negedge clk);
    irq_raise = 1'b0;
    while ((tmr_irq || busy) && n < 20) begin @(negedge clk); n++; end
    chk("irq ack timeout", {31'd0, tmr_irq}, 32'd0);
  endtask

  task automatic check_start_seq(input int base, input string nm);
    chk({nm, " write count"}, log_a.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < log_a.size()) begin
        chk($sformatf("%s addr%0d", nm, i), {29'd0, log_a[base+i]}, {29'd0, seq_exp[i].a});
        chk($sformatf("%s data%0d", nm, i), {16'd0, log_d[base+i]}, {16'd0, seq_exp[i].d});
        chk($sformatf("%s wn%0d", nm, i), {31'd0, log_wn[base+i]}, 32'd0);
        chk($sformatf("%s cyc%0d", nm, i), log_c[base+i], log_c[base] + i);
      end
    end
    if (base + 4 < log_a.size())
      chk({nm, " running rise"}, run_rise_cyc, log_c[base+4] + 1);
    chk({nm, " running"}, {31'd0, running}, 32'd1);
  endtask

  initial begin
    int base;
    int pb[4];
    int t0;
    int n;

    seq_exp[0] = '{3'd1, 16'h0008};
    seq_exp[1] = '{3'd2, 16'hD4BF};
    seq_exp[2] = '{3'd3, 16'h0001};
    seq_exp[3] = '{3'd0, 16'h0000};
    seq_exp[4] = '{3'd1, 16'h0007};
    // ch_div / exp_p packed ch3..ch0
    vecs[0] = '{{8'd0, 8'd4, 8'd2, 8'd1}, 5, {8'd0, 8'd1, 8'd2, 8'd5}};
    vecs[1] = '{{8'd5, 8'd0, 8'd1, 8'd3}, 6, {8'd1, 8'd0, 8'd6, 8'd2}};
    vecs[2] = '{{8'd1, 8'd7, 8'd2, 8'd2}, 7, {8'd7, 8'd1, 8'd3, 8'd3}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("rst wn", {31'd0, tmr_write_n}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst running", {31'd0, running}, 32'd0);
    chk("rst tick", tick_count, 32'd0);
    chk("rst ev", {28'd0, ev_pulse}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Snapshot and stop in IDLE are dropped
    base = log_a.size();
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    cfg_stop = 1'b1; @(negedge clk); cfg_stop = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle no bus", log_a.size() - base, 32'd0);
    chk("idle no snap", snap_cnt, 32'd0);

    // Start sequence
    base = log_a.size();
    start_timer(32'h0001D4BF);
    check_start_seq(base, "start");
    chk("run busy", {31'd0, busy}, 32'd0);

    // Channel divider vectors
    for (int v = 0; v < 3; v++) begin
      ch_div = vecs[v].div;
      start_timer(32'h0000_0100);
      base = log_a.size();
      for (int i = 0; i < 4; i++) pb[i] = pcnt[i];
      for (int k = 0; k < vecs[v].n_irq; k++) do_irq();
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        chk($sformatf("v%0d ch%0d pulses", v, i), pcnt[i] - pb[i], {24'd0, vecs[v].exp_p[i]});
      chk($sformatf("v%0d tick", v), tick_count, vecs[v].n_irq);
      chk($sformatf("v%0d bus beats", v), log_a.size() - base, vecs[v].n_irq);
      n = 0;
      for (int j = base; j < log_a.size(); j++)
        if (log_a[j] == 3'd0 && !log_wn[j]) n++;
      chk($sformatf("v%0d addr0 writes", v), n, vecs[v].n_irq);
    end

    // Snapshot
    base = log_a.size();
    t0 = snap_cnt;
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    n = 0;
    while (snap_cnt == t0 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("snap count", snap_cnt - t0, 32'd1);
    chk("snap value", snap_last, 32'h0005_1234);
    chk("snap beats", log_a.size() - base, 32'd3);
    if (base + 2 < log_a.size()) begin
      chk("snap w addr", {29'd0, log_a[base]}, 32'd4);
      chk("snap w wn", {31'd0, log_wn[base]}, 32'd0);
      chk("snap rl addr", {29'd0, log_a[base+1]}, 32'd4);
      chk("snap rl wn", {31'd0, log_wn[base+1]}, 32'd1);
      chk("snap rh addr", {29'd0, log_a[base+2]}, 32'd5);
      chk("snap rh wn", {31'd0, log_wn[base+2]}, 32'd1);
    end

    // irq arriving mid-snapshot is serviced right after
    t0 = snap_cnt;
    base = tick_count;
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    irq_raise = 1'b1; @(negedge clk); irq_raise = 1'b0;
    n = 0;
    while (tick_count == base && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("snap+irq snap count", snap_cnt - t0, 32'd1);
    chk("snap+irq tick", tick_count, base + 1);
    chk("snap+irq irq cleared", {31'd0, tmr_irq}, 32'd0);

    // tick_count wrap
    force dut.tick_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.tick_count;
    @(negedge clk);
    do_irq();
    chk("tick wrap", tick_count, 32'd0);

    // irq and stop together: ACK first, then HALT
    base = log_a.size();
    irq_raise = 1'b1; @(negedge clk);
    irq_raise = 1'b0; cfg_stop = 1'b1; @(negedge clk);
    cfg_stop = 1'b0;
    n = 0;
    while ((running || busy) && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("stop running", {31'd0, running}, 32'd0);
    chk("stop tick", tick_count, 32'd1);
    chk("stop beats", log_a.size() - base, 32'd2);
    if (base + 1 < log_a.size()) begin
      chk("stop ack addr", {29'd0, log_a[base]}, 32'd0);
      chk("stop halt addr", {29'd0, log_a[base+1]}, 32'd1);
      chk("stop halt data", {16'd0, log_d[base+1]}, 32'h0008);
      chk("stop halt wn", {31'd0, log_wn[base+1]}, 32'd0);
    end

    // Reset during S_PERH, then replay
    cfg_period = 32'h0001D4BF;
    cfg_start = 1'b1; @(negedge clk); cfg_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("perh addr", {29'd0, tmr_address}, 32'd3);
    chk("perh busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid rst cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("mid rst wn", {31'd0, tmr_write_n}, 32'd1);
    chk("mid rst addr", {29'd0, tmr_address}, 32'd0);
    chk("mid rst data", {16'd0, tmr_writedata}, 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst snap", snap_value, 32'd0);
    chk("mid rst snapv", {31'd0, snap_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    base = log_a.size();
    repeat (5) @(negedge clk);
    chk("post rst quiet", log_a.size() - base, 32'd0);
    base = log_a.size();
    start_timer(32'h0001D4BF);
    check_start_seq(base, "replay");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
